// File: rtl/bram_pkg.sv
// bram_pkg: FSM state encodings and BRAM read latency shared by bram_stream_reader
package bram_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam int RD_LAT = 1;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: BRAM read port plus output stream bundle
//   ram_enable/write_enable/address -> BRAM, ram_data <- BRAM
//   out_data/out_valid(/out_last) -> consumer, out_ready <- consumer
//   out_last exists only when BRAM_STREAM_READER_LAST_EN is defined
interface bram_stream_reader_if #(parameter int RAM_WIDTH = 8, parameter int RAM_ADDR_BITS = 10);
  logic                     ram_enable;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] address;
  logic [RAM_WIDTH-1:0]     ram_data;
  logic [RAM_WIDTH-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic                     out_last;
`endif
  modport master (
    output ram_enable, write_enable, address, out_data, out_valid,
`ifdef BRAM_STREAM_READER_LAST_EN
    output out_last,
`endif
    input  ram_data, out_ready
  );
  modport slave (
    input  ram_enable, write_enable, address, out_data, out_valid,
`ifdef BRAM_STREAM_READER_LAST_EN
    input  out_last,
`endif
    output ram_data, out_ready
  );
endinterface

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry valid/ready FIFO with occupancy output
//   in_valid/in_data: push (caller guarantees no overflow)
//   out_valid/out_data/out_ready: pop side, head held stable until popped
//   count: current occupancy 0..2
module stream_skid_buffer #(parameter int W = 8) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;
  always_comb begin
    pop = (cnt_q != 2'd0) && out_ready;
    mem_d = mem_q;
    mem_d[wr_q] = in_valid ? in_data : mem_q[wr_q];
    wr_d = wr_q ^ in_valid;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
  end
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = mem_q[rd_q];
  assign count     = cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads length words from a 1-cycle BRAM starting at start_addr and streams them out
//   clock, reset_n (async active-low); start/start_addr/length job request sampled in IDLE
//   busy high during READ/DRAIN, done 1-cycle pulse at completion
//   bus (master): BRAM read port and valid/ready output stream
//   BRAM_STREAM_READER_LAST_EN adds out_last on the final word
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] start_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  bram_stream_reader_if.master     bus
);
  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_ADDR_BITS:0]   rem_q, rem_d;
  logic [RD_LAT-1:0]        fl_q, fl_d;
  logic [1:0]               occ;
  logic                     ov, pop, issue;
  logic [RAM_WIDTH-1:0]     od;
  stream_skid_buffer #(.W(RAM_WIDTH)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (fl_q[RD_LAT-1]),
    .in_data   (bus.ram_data),
    .out_valid (ov),
    .out_data  (od),
    .out_ready (bus.out_ready),
    .count     (occ)
  );
  always_comb begin
    pop = ov && bus.out_ready;
    // reads still in flight count against the 2-entry buffer; a pop frees a slot this cycle
    issue = (state_q == READ) && ((int'(occ) + $countones(fl_q) < 2) || pop);
    fl_d = RD_LAT'({fl_q, issue});
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d = start_addr;
        rem_d = length;
        state_d = (length == '0) ? DONE : READ;
      end
      READ: if (issue) begin
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == (RAM_ADDR_BITS+1)'(1)) ? DRAIN : READ;
      end
      DRAIN: state_d = (fl_q == '0 && (occ == 2'd0 || (occ == 2'd1 && pop))) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      fl_q    <= fl_d;
    end
  end
  assign busy             = (state_q == READ) || (state_q == DRAIN);
  assign done             = state_q == DONE;
  assign bus.ram_enable   = issue;
  assign bus.write_enable = 1'b0;
  assign bus.address      = addr_q;
  assign bus.out_valid    = ov;
  assign bus.out_data     = od;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic [RAM_ADDR_BITS:0] left_q, left_d;
  always_comb begin
    left_d = (state_q == IDLE && start) ? length : (pop ? left_q - 1'b1 : left_q);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) left_q <= '0;
    else left_q <= left_d;
  end
  assign bus.out_last = ov && (left_q == (RAM_ADDR_BITS+1)'(1));
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed table-driven bench for bram_stream_reader
module tb_bram_stream_reader;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ram [1024];

  bram_stream_reader_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) bus ();

  bram_stream_reader #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus.ram_enable) bus.ram_data <= ram[bus.address];

  typedef struct {
    logic [9:0]  addr;
    logic [10:0] len;
    bit          toggle;
    int          poke;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ram_enable"}, 32'(bus.ram_enable), 0);
    chk({tag, "_write_enable"}, 32'(bus.write_enable), 0);
    chk({tag, "_address"}, 32'(bus.address), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
`ifdef BRAM_STREAM_READER_LAST_EN
    chk({tag, "_out_last"}, 32'(bus.out_last), 0);
`endif
  endtask

  task automatic run_job(input vec_t v, input int id);
    logic [7:0] words[$];
    logic [9:0] addrs[$];
    int cyc = 0, first_en = -1, first_val = -1, done_cyc = -1, busy_bad = 0, idle_bad = 0;
    bit stalled = 0, done_seen = 0;
    logic [7:0] hold = '0;
    string p = $sformatf("job%0d", id);
    start = 1'b1; start_addr = v.addr; length = v.len; bus.out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(negedge clock); cyc++;
      if (bus.ram_enable) begin
        if (first_en < 0) first_en = cyc;
        addrs.push_back(bus.address);
        chk({p, "_we"}, 32'(bus.write_enable), 0);
      end
      if (stalled) begin
        chk({p, "_stall_valid"}, 32'(bus.out_valid), 1);
        chk({p, "_stall_data"}, 32'(bus.out_data), 32'(hold));
      end
      stalled = 0;
      if (bus.out_valid) begin
        if (first_val < 0) first_val = cyc;
        if (bus.out_ready) begin
`ifdef BRAM_STREAM_READER_LAST_EN
          chk({p, "_out_last"}, 32'(bus.out_last), 32'(words.size() == int'(v.len) - 1));
`endif
          words.push_back(bus.out_data);
        end else begin
          stalled = 1; hold = bus.out_data;
        end
      end
`ifdef BRAM_STREAM_READER_LAST_EN
      else if (bus.out_last) busy_bad++;
`endif
      if (done) begin
        done_seen = 1; done_cyc = cyc;
        chk({p, "_busy_at_done"}, 32'(busy), 0);
      end else if (!busy) busy_bad++;
      @(posedge clock); #1;
      bus.out_ready = v.toggle ? ~bus.out_ready : 1'b1;
      start = (cyc + 1 == v.poke);
      if (start) begin start_addr = 10'h200; length = 11'd2; end
    end
    start = 1'b0;
    chk({p, "_done_seen"}, 32'(done_seen), 1);
    chk({p, "_done_cycle"}, done_cyc, v.exp_done);
    chk({p, "_busy_before_done"}, busy_bad, 0);
    chk({p, "_first_enable"}, first_en, v.len == 0 ? -1 : 1);
    chk({p, "_first_valid"}, first_val, v.len == 0 ? -1 : 3);
    chk({p, "_word_count"}, words.size(), 32'(v.len));
    chk({p, "_read_count"}, addrs.size(), 32'(v.len));
    foreach (words[k]) chk($sformatf("%s_word%0d", p, k), 32'(words[k]), 32'(8'(v.addr[7:0] + k)));
    foreach (addrs[k]) chk($sformatf("%s_addr%0d", p, k), 32'(addrs[k]), 32'(10'(v.addr + k)));
    @(negedge clock);
    chk({p, "_done_one_cycle"}, 32'(done), 0);
    chk({p, "_end_address"}, 32'(bus.address), 32'(10'(v.addr + v.len)));
    repeat (4) begin
      @(negedge clock);
      if (bus.ram_enable || bus.out_valid || busy || done) idle_bad++;
    end
    chk({p, "_idle_after"}, idle_bad, 0);
    @(posedge clock); #1 bus.out_ready = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    int n, rst_done;
    vecs[0] = '{10'h010, 11'd4,    1'b0, 0, 7};
    vecs[1] = '{10'h010, 11'd4,    1'b1, 0, 10};
    vecs[2] = '{10'h3FE, 11'd4,    1'b0, 0, 7};
    vecs[3] = '{10'h005, 11'd0,    1'b0, 0, 1};
    vecs[4] = '{10'h010, 11'd4,    1'b0, 2, 7};
    vecs[5] = '{10'h040, 11'd1,    1'b1, 0, 4};
    vecs[6] = '{10'h123, 11'd1024, 1'b0, 0, 1027};
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    bus.out_ready = 1'b1;
    bus.ram_data = '0;
    #2 check_reset_vals("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 7; i++) run_job(vecs[i], i);
    start = 1'b1; start_addr = 10'h020; length = 11'd8;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) n++;
    end
    chk("abort_words_before_reset", n, 2);
    @(posedge clock); #1 reset_n = 1'b0;
    #1 check_reset_vals("abort");
    rst_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || bus.out_valid || bus.ram_enable) rst_done++;
    end
    chk("abort_quiet_in_reset", rst_done, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    rst_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || bus.out_valid || bus.ram_enable) rst_done++;
    end
    chk("abort_no_done_after_release", rst_done, 0);
    @(posedge clock); #1;
    run_job(vecs[0], 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
